fetch_unit: RTL

Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the PC, issues requests on a variable-latency instruction-memory port, and applies branch/jump redirects from ID and load-use stalls from the hazard unit. It drives the IF/ID register's write-enable and flush, so that ID only ever sees a valid instruction, a held instruction, or a NOP bubble (all-zero word).

---
 rtl/fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem port,
// and drives the IF/ID write-enable and flush for stalls, waits and redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_PCplus4,
    output logic        IF_ID_Write,
    output logic        IF_ID_FLUSH
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        WAIT_DROP
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] drop_addr;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc4;
    logic        avail;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        o_instr   = imem_rdata;
        o_PCplus4 = pc_plus4;
        avail     = 1'b0;
        unique case (state)
            FETCH: begin
                imem_req = !rst;
                avail    = imem_ready;
            end
            HOLD: begin
                o_instr   = buf_instr;
                o_PCplus4 = buf_pc4;
                avail     = 1'b1;
            end
            WAIT_DROP: begin
                imem_req  = !rst;
                imem_addr = drop_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        IF_ID_Write = 1'b0;
        IF_ID_FLUSH = 1'b0;
        if (rst || redirect) begin
            IF_ID_FLUSH = 1'b1;
        end else if (stall) begin
            IF_ID_FLUSH = 1'b0;
        end else if (avail) begin
            IF_ID_Write = 1'b1;
        end else begin
            IF_ID_FLUSH = 1'b1;
        end
    end

    // A redirect with a request still in flight must wait for that response
    // at the old address before the target can be requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop_addr <= 32'd0;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (!imem_ready) begin
                            drop_addr <= pc;
                            state     <= WAIT_DROP;
                        end
                    end else if (imem_ready) begin
                        if (stall) begin
                            buf_instr <= imem_rdata;
                            buf_pc4   <= pc_plus4;
                            state     <= HOLD;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!stall) begin
                        pc    <= buf_pc4;
                        state <= FETCH;
                    end
                end
                WAIT_DROP: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                    end
                    if (imem_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule
